// File: rtl/vga_palette_pkg.sv
// Shared definitions for the VGA colour look-up table.
// Holds the built-in 16-colour default palette, its width-adaptation helper and the FSM state type.
// No logic of its own; consumers import vga_palette_pkg::*.
package vga_palette_pkg;

    // Controller state: INIT walks the default palette into RAM, RUN serves pixels and writes.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } pal_state_e;

    // Built-in 8-bit colours loaded after every reset (entries 16 and up default to black).
    localparam logic [7:0] DEFAULT_PALETTE [0:15] = '{
        8'h00, 8'h03, 8'h0C, 8'h0F, 8'hC0, 8'hC3, 8'hF0, 8'hFF,
        8'h7F, 8'h02, 8'h08, 8'h0A, 8'h80, 8'h82, 8'h90, 8'h92
    };

    // Default colour for entry idx, right-justified in the low out_w bits of the result.
    // The 8-bit base is left-aligned in a 24-bit word and shifted down, so wider outputs
    // get zero LSBs and narrower outputs keep only the top out_w bits of the base.
    function automatic logic [23:0] default_color(input int unsigned idx, input int unsigned out_w);
        logic [7:0]  base;
        logic [23:0] wide;
        base = (idx < 16) ? DEFAULT_PALETTE[idx[3:0]] : 8'h00;
        wide = {base, 16'h0000};
        return wide >> (24 - out_w);
    endfunction

endpackage

// File: rtl/vga_palette_lut_ram.sv
// Palette storage: 2^AW x DW, one write port, one registered read port.
// Latency: read data valid one cycle after raddr_i; read-first on same-address collision.
// Backpressure: none; a write and a read are accepted every cycle.
module palette_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Array write; the non-blocking update keeps a same-cycle read on the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, cleared by reset so no stale colour sits in the pipeline.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_palette_lut.sv
// Programmable VGA colour look-up table: pixel index -> packed colour; default palette loaded after reset.
// Latency: 2 cycles index-to-colour, one pixel per clock; INIT takes 2^IDX_W cycles after reset release.
// Backpressure: none; writes while wr_ready=0 are dropped. Optional blink: define PALETTE_BLINK_EN.
module vga_palette_lut
    import vga_palette_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int OUT_W        = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             pix_blank,
    input  logic             pix_blink,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    output logic             wr_ready,
    output logic             init_done,
    output logic             vga_valid,
    output logic [OUT_W-1:0] vga_color
);

    localparam logic [IDX_W-1:0] LAST_ADDR = '1;

    pal_state_e       state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [OUT_W-1:0] ram_wdata;
    logic [OUT_W-1:0] ram_rdata;
    logic [OUT_W-1:0] ram_def;

    logic             vld1_q, blank1_q;
    logic             blink_mask;
    logic             vga_valid_q, vga_valid_d;
    logic [OUT_W-1:0] vga_color_q, vga_color_d;

    assign ram_def = OUT_W'(default_color(int'(addr_q), OUT_W));

    // Next-state and palette write mux: INIT owns the write port, RUN hands it to the control side.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        case (state_q)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = ram_def;
                addr_d    = addr_q + IDX_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_we = wr_en;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // FSM and init address counter; any reset cycle restarts the default load from entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign wr_ready  = (state_q == RUN);
    assign init_done = (state_q == RUN);

    palette_ram #(
        .AW (IDX_W),
        .DW (OUT_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (ram_we & rst_n),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (pix_idx),
        .rdata_o (ram_rdata)
    );

    // Stage 1 side-band: valid and blank travel alongside the palette read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q   <= 1'b0;
            blank1_q <= 1'b0;
        end else begin
            vld1_q   <= pix_valid;
            blank1_q <= pix_blank;
        end
    end

`ifdef PALETTE_BLINK_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           hidden_q, hidden_d;
    logic           blink1_q;

    // Blink phase: count frames and toggle visibility each time the counter wraps.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        hidden_d    = hidden_q;
        if (frame_start) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                hidden_d    = ~hidden_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    // Blink state registers, plus the per-pixel blink attribute delayed to stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            hidden_q    <= 1'b0;
            blink1_q    <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            hidden_q    <= hidden_d;
            blink1_q    <= pix_blink;
        end
    end

    assign blink_mask = hidden_q & blink1_q;
`else
    logic unused_blink;
    assign unused_blink = pix_blink ^ frame_start ^ (BLINK_FRAMES > 0);
    assign blink_mask   = 1'b0;
`endif

    // Stage 2 mask: blanked, invalid, still-initialising or blinked-out pixels become black.
    always_comb begin
        vga_valid_d = vld1_q;
        vga_color_d = ram_rdata;
        if (blank1_q || !vld1_q || (state_q != RUN) || blink_mask) begin
            vga_color_d = '0;
        end
    end

    // Stage 2 output register feeding the DAC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_valid_q <= 1'b0;
            vga_color_q <= '0;
        end else begin
            vga_valid_q <= vga_valid_d;
            vga_color_q <= vga_color_d;
        end
    end

    assign vga_valid = vga_valid_q;
    assign vga_color = vga_color_q;

endmodule

// File: tb/tb_vga_palette_lut.sv
// Directed bench for vga_palette_lut (IDX_W=4, OUT_W=8, BLINK_FRAMES=2).
// Latency: outputs checked 2 edges after the index is driven.
// Backpressure: none; blink expectations follow PALETTE_BLINK_EN.
module tb_vga_palette_lut;

    logic       clk;
    logic       rst_n;
    logic       pix_valid;
    logic [3:0] pix_idx;
    logic       pix_blank;
    logic       pix_blink;
    logic       frame_start;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       vga_valid;
    logic [7:0] vga_color;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       vld;
        logic [3:0] idx;
        logic       blank;
        logic       exp_vld;
        logic [7:0] exp_col;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] pal_exp [16];
    logic [7:0] blink_exp [6];

    vga_palette_lut #(
        .IDX_W        (4),
        .OUT_W        (8),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_idx     (pix_idx),
        .pix_blank   (pix_blank),
        .pix_blink   (pix_blink),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .init_done   (init_done),
        .vga_valid   (vga_valid),
        .vga_color   (vga_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        pal_exp = '{8'h00, 8'h03, 8'h0C, 8'h0F, 8'hC0, 8'hC3, 8'hF0, 8'hFF,
                    8'h7F, 8'h02, 8'h08, 8'h0A, 8'h80, 8'h82, 8'h90, 8'h92};
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{vld: 1'b1, idx: 4'(i), blank: 1'b0, exp_vld: 1'b1, exp_col: pal_exp[i]};
        end
        tbl[16] = '{vld: 1'b1, idx: 4'd7, blank: 1'b1, exp_vld: 1'b1, exp_col: 8'h00};
        tbl[17] = '{vld: 1'b0, idx: 4'd7, blank: 1'b0, exp_vld: 1'b0, exp_col: 8'h00};
`ifdef PALETTE_BLINK_EN
        blink_exp = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
`else
        blink_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif

        rst_n = 1'b0; pix_valid = 1'b0; pix_idx = '0; pix_blank = 1'b0;
        pix_blink = 1'b0; frame_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state.
        step(); step();
        check("rst_vga_valid", 32'(vga_valid), 32'd0);
        check("rst_vga_color", 32'(vga_color), 32'd0);
        check("rst_wr_ready",  32'(wr_ready),  32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Release reset; pixels and a write to entry 2 presented during INIT.
        rst_n = 1'b1; pix_valid = 1'b1; pix_idx = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hAA;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) begin
                check("init_pix_valid", 32'(vga_valid), 32'd1);
                check("init_pix_color", 32'(vga_color), 32'd0);
                check("init_wr_ready",  32'(wr_ready),  32'd0);
            end
            if (k == 15) begin
                check("init_done_early", 32'(init_done), 32'd0);
                wr_en = 1'b0;
            end
        end
        check("init_done_rise", 32'(init_done), 32'd1);
        check("wr_ready_rise",  32'(wr_ready),  32'd1);

        // Table: default palette readback, blank and invalid pixels.
        for (int i = 0; i <= 18; i++) begin
            if (i < 18) begin
                pix_valid = tbl[i].vld; pix_idx = tbl[i].idx; pix_blank = tbl[i].blank;
            end else begin
                pix_valid = 1'b0; pix_blank = 1'b0;
            end
            step();
            if (i >= 1) begin
                check($sformatf("tbl%0d_valid", i - 1), 32'(vga_valid), 32'(tbl[i-1].exp_vld));
                check($sformatf("tbl%0d_color", i - 1), 32'(vga_color), 32'(tbl[i-1].exp_col));
            end
        end

        // Same-cycle write/read of entry 3 is read-first; the next read sees the new value.
        pix_valid = 1'b1; pix_idx = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        step();
        check("collide_old", 32'(vga_color), 32'h0F);
        step();
        check("after_write_new", 32'(vga_color), 32'h5A);
        step();
        check("stream_new", 32'(vga_color), 32'h5A);

        // Write entry 5, read it back, then pulse reset for one cycle mid-stream.
        pix_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
        step();
        wr_en = 1'b0; pix_valid = 1'b1; pix_idx = 4'd5;
        step(); step();
        check("entry5_written", 32'(vga_color), 32'h11);
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(vga_valid), 32'd0);
        check("midrst_color", 32'(vga_color), 32'd0);
        check("midrst_ready", 32'(wr_ready),  32'd0);
        rst_n = 1'b1;
        repeat (16) step();
        check("reinit_done", 32'(init_done), 32'd1);
        step(); step();
        check("entry5_default", 32'(vga_color), 32'hC3);

        // Blink on index 7: frame 0 is the one in progress after reset.
        pix_idx = 4'd7; pix_blink = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if (f > 0) begin
                frame_start = 1'b1;
                step();
                frame_start = 1'b0;
            end
            repeat (4) step();
            check($sformatf("blink_frame%0d", f), 32'(vga_color), 32'(blink_exp[f]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
